// File: rtl/rf_read_stage_pkg.sv
// Shared types for the operand-read stage: bypass-source and entry/output bundles.
// The helper decides whether one source operand is produced by a given bypass source.
package rf_read_stage_pkg;

  localparam int REG_AW    = 5;
  localparam int DATA_W    = 32;
  localparam int PAYLOAD_W = 64;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

  typedef struct packed {
    logic              we;
    logic              is_load;
    logic              data_ok;
    logic [REG_AW-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } bypass_src_t;

  typedef struct packed {
    logic                 use1;
    logic                 use2;
    logic [REG_AW-1:0]    raddr1;
    logic [REG_AW-1:0]    raddr2;
    logic [REG_AW-1:0]    waddr;
    logic                 we;
    logic                 is_load;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  typedef struct packed {
    logic [DATA_W-1:0]    src1;
    logic [DATA_W-1:0]    src2;
    logic [REG_AW-1:0]    waddr;
    logic                 we;
    logic                 is_load;
    logic [PAYLOAD_W-1:0] payload;
  } out_bundle_t;

  // Register 0 is hard-wired to zero, so nothing ever forwards into it.
  function automatic logic src_match(input logic              use_src,
                                     input logic [REG_AW-1:0] raddr,
                                     input bypass_src_t       src);
    return use_src && (raddr != '0) && src.we && (src.waddr == raddr);
  endfunction

endpackage

// File: rtl/rf_fwd_sel.sv
// Resolves one source operand against EXE/MEM/WB bypasses and the regfile read data,
// and flags a hazard when the matching producer's data is not available yet.
module rf_fwd_sel
  import rf_read_stage_pkg::*;
(
  input  logic [REG_AW-1:0] i_raddr,
  input  logic              i_use,
  input  logic [DATA_W-1:0] i_rf_rdata,
  input  bypass_src_t       i_exe,
  input  bypass_src_t       i_mem,
  input  bypass_src_t       i_wb,
  output logic [DATA_W-1:0] o_data,
  output logic              o_hazard
);

  logic w_exe_hit;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_exe_hit = src_match(i_use, i_raddr, i_exe);
  assign w_mem_hit = src_match(i_use, i_raddr, i_mem);
  assign w_wb_hit  = src_match(i_use, i_raddr, i_wb);

  always_comb begin
    // NOTE: default assigned first so every path drives o_data; a missing branch would infer a latch.
    o_data = i_rf_rdata;
    if (i_raddr == '0) begin
      o_data = '0;
    end else if (w_exe_hit) begin
      o_data = i_exe.wdata;
    end else if (w_mem_hit) begin
      o_data = i_mem.wdata;
    end else if (w_wb_hit) begin
      o_data = i_wb.wdata;
    end
  end

  // A matching load whose data has not returned blocks the operand.
  assign o_hazard = (w_exe_hit && i_exe.is_load && !i_exe.data_ok) ||
                    (w_mem_hit && i_mem.is_load && !i_mem.data_ok) ||
                    (w_wb_hit  && i_wb.is_load  && !i_wb.data_ok);

endmodule

// File: rtl/rf_read_stage.sv
// Operand-read stage: holds one decoded instruction, reads the regfile, forwards from
// EXE/MEM/WB, stalls on load-use hazards and hands resolved operands downstream.
module rf_read_stage
  import rf_read_stage_pkg::REG_AW, rf_read_stage_pkg::bypass_src_t, rf_read_stage_pkg::entry_t,
         rf_read_stage_pkg::out_bundle_t, rf_read_stage_pkg::stage_state_e,
         rf_read_stage_pkg::ST_EMPTY, rf_read_stage_pkg::ST_FULL;
#(
  parameter int PAYLOAD_W = 64,
  parameter int DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_AW-1:0]    in_raddr1,
  input  logic [REG_AW-1:0]    in_raddr2,
  input  logic                 in_use1,
  input  logic                 in_use2,
  input  logic [REG_AW-1:0]    in_waddr,
  input  logic                 in_we,
  input  logic                 in_is_load,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic [REG_AW-1:0]    rf_raddr1,
  output logic [REG_AW-1:0]    rf_raddr2,
  input  logic [DATA_W-1:0]    rf_rdata1,
  input  logic [DATA_W-1:0]    rf_rdata2,
  input  logic                 exe_we,
  input  logic                 exe_is_load,
  input  logic [REG_AW-1:0]    exe_waddr,
  input  logic [DATA_W-1:0]    exe_wdata,
  input  logic                 mem_we,
  input  logic                 mem_is_load,
  input  logic                 mem_data_ok,
  input  logic [REG_AW-1:0]    mem_waddr,
  input  logic [DATA_W-1:0]    mem_wdata,
  input  logic                 wb_we,
  input  logic [REG_AW-1:0]    wb_waddr,
  input  logic [DATA_W-1:0]    wb_wdata,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_src1,
  output logic [DATA_W-1:0]    out_src2,
  output logic [REG_AW-1:0]    out_waddr,
  output logic                 out_we,
  output logic                 out_is_load,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [31:0]          stall_cnt
);

  stage_state_e r_state;
  stage_state_e w_state_next;
  entry_t       r_entry;
  logic [31:0]  r_stall_cnt;

  bypass_src_t  w_exe;
  bypass_src_t  w_mem;
  bypass_src_t  w_wb;
  out_bundle_t  w_out;

  logic [DATA_W-1:0] w_src1;
  logic [DATA_W-1:0] w_src2;
  logic w_haz1;
  logic w_haz2;
  logic w_hazard;
  logic w_valid;
  logic w_ready_go;
  logic w_accept;
  logic w_out_fire;
  logic w_load;

  // A load in EXE never has its data yet; the WB write data is always final.
  assign w_exe = '{we: exe_we, is_load: exe_is_load, data_ok: 1'b0,
                   waddr: exe_waddr, wdata: exe_wdata};
  assign w_mem = '{we: mem_we, is_load: mem_is_load, data_ok: mem_data_ok,
                   waddr: mem_waddr, wdata: mem_wdata};
  assign w_wb  = '{we: wb_we, is_load: 1'b0, data_ok: 1'b1,
                   waddr: wb_waddr, wdata: wb_wdata};

  rf_fwd_sel u_fwd_src1 (
    .i_raddr    (r_entry.raddr1),
    .i_use      (r_entry.use1),
    .i_rf_rdata (rf_rdata1),
    .i_exe      (w_exe),
    .i_mem      (w_mem),
    .i_wb       (w_wb),
    .o_data     (w_src1),
    .o_hazard   (w_haz1)
  );

  rf_fwd_sel u_fwd_src2 (
    .i_raddr    (r_entry.raddr2),
    .i_use      (r_entry.use2),
    .i_rf_rdata (rf_rdata2),
    .i_exe      (w_exe),
    .i_mem      (w_mem),
    .i_wb       (w_wb),
    .o_data     (w_src2),
    .o_hazard   (w_haz2)
  );

  assign w_valid    = (r_state == ST_FULL);
  assign w_hazard   = w_haz1 || w_haz2;
  assign w_ready_go = w_valid && !w_hazard;
  assign out_valid  = w_ready_go && !flush;
  assign in_ready   = !flush && (!w_valid || (w_ready_go && out_ready));
  assign w_accept   = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A new accept takes priority over the outgoing handshake, so back-to-back has no bubble.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    if (flush) begin
      w_state_next = ST_EMPTY;
    end else if (w_accept) begin
      w_state_next = ST_FULL;
      w_load       = 1'b1;
    end else if (w_out_fire) begin
      w_state_next = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the entry is reset because out_* and rf_raddr* are visible immediately after reset.
    if (reset) begin
      r_entry <= '0;
    end else if (w_load) begin
      r_entry <= '{use1: in_use1, use2: in_use2, raddr1: in_raddr1, raddr2: in_raddr2,
                   waddr: in_waddr, we: in_we, is_load: in_is_load, payload: in_payload};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_valid && w_hazard && !flush && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign w_out = '{src1: w_src1, src2: w_src2, waddr: r_entry.waddr, we: r_entry.we,
                   is_load: r_entry.is_load, payload: r_entry.payload};

  assign rf_raddr1   = r_entry.raddr1;
  assign rf_raddr2   = r_entry.raddr2;
  assign out_src1    = w_out.src1;
  assign out_src2    = w_out.src2;
  assign out_waddr   = w_out.waddr;
  assign out_we      = w_out.we;
  assign out_is_load = w_out.is_load;
  assign out_payload = w_out.payload;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_rf_read_stage.sv
// Bench for rf_read_stage: directed scenarios plus randomized traffic checked against
// a behavioural model of the stage built from the forwarding and handshake rules.
module tb_rf_read_stage;

  localparam int DW = 32;
  localparam int PW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready;
  logic [4:0]    in_raddr1, in_raddr2, in_waddr;
  logic          in_use1, in_use2, in_we, in_is_load;
  logic [PW-1:0] in_payload;
  logic [4:0]    rf_raddr1, rf_raddr2;
  logic [DW-1:0] rf_rdata1, rf_rdata2;
  logic          exe_we, exe_is_load;
  logic [4:0]    exe_waddr;
  logic [DW-1:0] exe_wdata;
  logic          mem_we, mem_is_load, mem_data_ok;
  logic [4:0]    mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          wb_we;
  logic [4:0]    wb_waddr;
  logic [DW-1:0] wb_wdata;
  logic          flush;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_src1, out_src2;
  logic [4:0]    out_waddr;
  logic          out_we, out_is_load;
  logic [PW-1:0] out_payload;
  logic [31:0]   stall_cnt;

  int checks   = 0;
  int failures = 0;

  // Bench-side register file; index 0 stays zero.
  logic [DW-1:0] rf_mem [32];
  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign rf_rdata2 = rf_mem[rf_raddr2];

  // Behavioural model of the held instruction.
  logic          m_valid;
  logic [4:0]    m_ra1, m_ra2, m_wa;
  logic          m_u1, m_u2, m_we, m_ld;
  logic [PW-1:0] m_pl;
  logic [31:0]   m_stall;

  always #5 clk = ~clk;

  rf_read_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_raddr1(in_raddr1), .in_raddr2(in_raddr2),
    .in_use1(in_use1), .in_use2(in_use2),
    .in_waddr(in_waddr), .in_we(in_we), .in_is_load(in_is_load), .in_payload(in_payload),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .exe_we(exe_we), .exe_is_load(exe_is_load), .exe_waddr(exe_waddr), .exe_wdata(exe_wdata),
    .mem_we(mem_we), .mem_is_load(mem_is_load), .mem_data_ok(mem_data_ok),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_src1(out_src1), .out_src2(out_src2),
    .out_waddr(out_waddr), .out_we(out_we), .out_is_load(out_is_load),
    .out_payload(out_payload), .stall_cnt(stall_cnt)
  );

  // Advance one clock; the regfile write lands on the edge, inputs change 1ns later.
  task automatic tick();
    @(posedge clk);
    if (wb_we && wb_waddr != 5'd0) rf_mem[wb_waddr] = wb_wdata;
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_raddr1 = 0; in_raddr2 = 0; in_use1 = 0; in_use2 = 0;
    in_waddr = 0; in_we = 0; in_is_load = 0; in_payload = '0;
    exe_we = 0; exe_is_load = 0; exe_waddr = 0; exe_wdata = 0;
    mem_we = 0; mem_is_load = 0; mem_data_ok = 0; mem_waddr = 0; mem_wdata = 0;
    wb_we = 0; wb_waddr = 0; wb_wdata = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  // Operand value from the rules: zero register, then EXE > MEM > WB > regfile.
  function automatic logic [DW-1:0] m_operand(input logic [4:0] ra, input logic u);
    logic          we_v [3];
    logic [4:0]    wa_v [3];
    logic [DW-1:0] wd_v [3];
    we_v[0] = exe_we;    we_v[1] = mem_we;    we_v[2] = wb_we;
    wa_v[0] = exe_waddr; wa_v[1] = mem_waddr; wa_v[2] = wb_waddr;
    wd_v[0] = exe_wdata; wd_v[1] = mem_wdata; wd_v[2] = wb_wdata;
    if (ra == 5'd0) return '0;
    for (int s = 0; s < 3; s++) begin
      if (u && we_v[s] && wa_v[s] == ra) return wd_v[s];
    end
    return rf_mem[ra];
  endfunction

  function automatic logic m_hazard(input logic [4:0] ra, input logic u);
    if (ra == 5'd0 || !u) return 1'b0;
    return (exe_we && exe_is_load && exe_waddr == ra) ||
           (mem_we && mem_is_load && !mem_data_ok && mem_waddr == ra);
  endfunction

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
    checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0h exp=0", stall_cnt); end
    in_valid = 1; in_raddr1 = 5'd4; in_use1 = 1; in_waddr = 5'd6; in_we = 1;
    in_payload = 64'hCAFE_F00D_1234_5678; out_ready = 0;
    tick();
    exe_we = 1; exe_is_load = 1; exe_waddr = 5'd4;
    tick();
    tick();
    checks++; if (stall_cnt !== 32'd2) begin failures++; $display("FAIL prereset_stall_cnt got=%0h exp=2", stall_cnt); end
    #2 reset = 1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL async_reset_out_valid got=%0h exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL async_reset_in_ready got=%0h exp=1", in_ready); end
    checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL async_reset_stall_cnt got=%0h exp=0", stall_cnt); end
    checks++; if ({rf_raddr1, out_payload} !== '0) begin failures++; $display("FAIL async_reset_entry got=%0h/%0h exp=0", rf_raddr1, out_payload); end
    tick();
    idle();
    reset = 0;
  endtask

  task automatic test_exe_priority();
    do_reset();
    rf_mem[5] = 32'h11;
    in_valid = 1; in_raddr1 = 5'd5; in_use1 = 1;
    exe_we = 1; exe_waddr = 5'd5; exe_wdata = 32'hAA;
    mem_we = 1; mem_waddr = 5'd5; mem_wdata = 32'hBB;
    out_ready = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL prio_pre_out_valid got=%0h exp=0", out_valid); end
    tick();
    in_valid = 0;
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL prio_out_valid got=%0h exp=1", out_valid); end
    checks++; if (out_src1 !== 32'hAA) begin failures++; $display("FAIL prio_exe got=%0h exp=aa", out_src1); end
    checks++; if (rf_raddr1 !== 5'd5) begin failures++; $display("FAIL prio_rf_raddr1 got=%0h exp=5", rf_raddr1); end
    exe_we = 0;
    #1;
    checks++; if (out_src1 !== 32'hBB) begin failures++; $display("FAIL prio_mem got=%0h exp=bb", out_src1); end
    mem_we = 0;
    #1;
    checks++; if (out_src1 !== 32'h11) begin failures++; $display("FAIL prio_rf got=%0h exp=11", out_src1); end
    out_ready = 1;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL prio_drain got=%0h exp=0", out_valid); end
  endtask

  task automatic test_wb_bypass();
    do_reset();
    rf_mem[7] = 32'h0;
    in_valid = 1; in_raddr2 = 5'd7; in_use2 = 1; in_waddr = 5'd9; in_we = 1;
    in_payload = 64'h0123_4567_89AB_CDEF;
    tick();
    in_valid = 0;
    wb_we = 1; wb_waddr = 5'd7; wb_wdata = 32'h1234;
    #1;
    checks++; if (out_src2 !== 32'h1234) begin failures++; $display("FAIL wb_src2 got=%0h exp=1234", out_src2); end
    checks++; if ({out_valid, out_we, out_waddr} !== {1'b1, 1'b1, 5'd9}) begin failures++; $display("FAIL wb_ctrl got=%0h exp=%0h", {out_valid, out_we, out_waddr}, {1'b1, 1'b1, 5'd9}); end
    checks++; if (out_payload !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL wb_payload got=%0h exp=123456789abcdef", out_payload); end
    tick();
    wb_we = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL wb_drain got=%0h exp=0", out_valid); end
  endtask

  task automatic test_load_use_stall();
    do_reset();
    in_valid = 1; in_raddr1 = 5'd3; in_use1 = 1;
    tick();
    in_valid = 0;
    exe_we = 1; exe_is_load = 1; exe_waddr = 5'd3;
    #1;
    checks++; if ({out_valid, in_ready} !== 2'b00) begin failures++; $display("FAIL lu_exe got=%0b exp=00", {out_valid, in_ready}); end
    tick();
    exe_we = 0; exe_is_load = 0;
    mem_we = 1; mem_is_load = 1; mem_data_ok = 0; mem_waddr = 5'd3;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lu_mem%0d got=%0h exp=0", i, out_valid); end
      tick();
    end
    mem_data_ok = 1; mem_wdata = 32'hDEAD;
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lu_release got=%0h exp=1", out_valid); end
    checks++; if (out_src1 !== 32'hDEAD) begin failures++; $display("FAIL lu_src1 got=%0h exp=dead", out_src1); end
    checks++; if (stall_cnt !== 32'd3) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=3", stall_cnt); end
    tick();
    checks++; if ({out_valid, stall_cnt} !== {1'b0, 32'd3}) begin failures++; $display("FAIL lu_after got=%0h exp=%0h", {out_valid, stall_cnt}, {1'b0, 32'd3}); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    in_valid = 1; in_raddr1 = 5'd0; in_use1 = 1; out_ready = 0;
    tick();
    in_valid = 0;
    exe_we = 1; exe_waddr = 5'd0; exe_wdata = 32'hFF; exe_is_load = 1;
    #1;
    checks++; if (out_src1 !== 32'd0) begin failures++; $display("FAIL zero_src1 got=%0h exp=0", out_src1); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL zero_out_valid got=%0h exp=1", out_valid); end
    tick();
    checks++; if ({out_valid, stall_cnt} !== {1'b1, 32'd0}) begin failures++; $display("FAIL zero_no_stall got=%0h exp=%0h", {out_valid, stall_cnt}, {1'b1, 32'd0}); end
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] pl [4];
    logic c_iv [6], c_or [6], c_fl [6], e_ir [6], e_ov [6];
    int c_pi [6], e_pi [6];
    int fires = 0;
    pl[0] = 64'hA; pl[1] = 64'hB; pl[2] = 64'hC; pl[3] = 64'hD;
    c_iv = '{1, 1, 1, 1, 1, 0}; c_pi = '{0, 1, 2, 2, 3, 0};
    c_or = '{1, 1, 0, 1, 1, 1}; c_fl = '{0, 0, 0, 0, 1, 0};
    e_ir = '{1, 1, 0, 1, 0, 1}; e_ov = '{0, 1, 1, 1, 0, 0};
    e_pi = '{0, 0, 1, 1, 0, 0};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      in_valid = c_iv[c]; in_payload = pl[c_pi[c]]; out_ready = c_or[c]; flush = c_fl[c];
      #1;
      checks++; if ({in_ready, out_valid} !== {e_ir[c], e_ov[c]}) begin failures++; $display("FAIL b2b_hs c%0d got=%0b exp=%0b", c, {in_ready, out_valid}, {e_ir[c], e_ov[c]}); end
      if (e_ov[c]) begin
        checks++; if (out_payload !== pl[e_pi[c]]) begin failures++; $display("FAIL b2b_payload c%0d got=%0h exp=%0h", c, out_payload, pl[e_pi[c]]); end
      end
      if (out_valid && out_ready) fires++;
      tick();
    end
    checks++; if (fires !== 2) begin failures++; $display("FAIL b2b_deliveries got=%0d exp=2", fires); end
    idle();
  endtask

  task automatic test_random();
    logic [178:0] e_vec, a_vec;
    logic haz, e_ov, e_ir;
    do_reset();
    m_valid = 0; m_ra1 = 0; m_ra2 = 0; m_wa = 0; m_u1 = 0; m_u2 = 0;
    m_we = 0; m_ld = 0; m_pl = '0; m_stall = 0;
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_raddr1 = 5'($urandom_range(0, 3)); in_raddr2 = 5'($urandom_range(0, 3));
      in_use1 = ($urandom_range(0, 3) != 0); in_use2 = ($urandom_range(0, 3) != 0);
      in_waddr = 5'($urandom_range(0, 31)); in_we = 1'($urandom); in_is_load = 1'($urandom);
      in_payload = {32'($urandom), 32'($urandom)};
      exe_we = 1'($urandom); exe_is_load = ($urandom_range(0, 2) == 0);
      exe_waddr = 5'($urandom_range(0, 3)); exe_wdata = 32'($urandom);
      mem_we = 1'($urandom); mem_is_load = ($urandom_range(0, 2) == 0); mem_data_ok = 1'($urandom);
      mem_waddr = 5'($urandom_range(0, 3)); mem_wdata = 32'($urandom);
      wb_we = 1'($urandom); wb_waddr = 5'($urandom_range(0, 3)); wb_wdata = 32'($urandom);
      flush = ($urandom_range(0, 15) == 0); out_ready = ($urandom_range(0, 3) != 0);
      #1;
      haz  = m_valid && (m_hazard(m_ra1, m_u1) || m_hazard(m_ra2, m_u2));
      e_ov = m_valid && !haz && !flush;
      e_ir = !flush && (!m_valid || (!haz && out_ready));
      e_vec = {e_ov, e_ir, m_ra1, m_ra2, m_operand(m_ra1, m_u1), m_operand(m_ra2, m_u2),
               m_wa, m_we, m_ld, m_pl, m_stall};
      a_vec = {out_valid, in_ready, rf_raddr1, rf_raddr2, out_src1, out_src2,
               out_waddr, out_we, out_is_load, out_payload, stall_cnt};
      checks++; if (a_vec !== e_vec) begin failures++; $display("FAIL rand c%0d got=%0h exp=%0h", c, a_vec, e_vec); end
      if (haz && !flush && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (flush) m_valid = 0;
      else if (in_valid && e_ir) begin
        m_valid = 1; m_ra1 = in_raddr1; m_ra2 = in_raddr2; m_u1 = in_use1; m_u2 = in_use2;
        m_wa = in_waddr; m_we = in_we; m_ld = in_is_load; m_pl = in_payload;
      end else if (e_ov && out_ready) m_valid = 0;
      tick();
    end
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    rf_mem[0] = '0;
    for (int i = 1; i < 32; i++) rf_mem[i] = 32'($urandom);
    #3;
    test_reset();
    test_exe_priority();
    test_wb_bypass();
    test_load_use_stall();
    test_zero_reg();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
